// File: rtl/snake_state_engine.sv
// Snake geometry engine: holds head/body segments, advances one block per move_tick
// with wrap-around, detects self-collision and streams body segments to the renderer.
module snake_state_engine #(
   parameter int GRID_W   = 80,
   parameter int GRID_H   = 60,
   parameter int START_X  = 40,
   parameter int START_Y  = 30,
   parameter int INIT_LEN = 3,
   parameter int MAX_LEN  = 15
) (
   input  logic       clock_25,
   input  logic       reset,
   input  logic       game_enable,
   input  logic       move_tick,
   input  logic [1:0] direction,
   input  logic       grow,
   output logic [6:0] snake_head_x,
   output logic [6:0] snake_head_y,
   output logic [6:0] snake_body_x,
   output logic [6:0] snake_body_y,
   output logic       en_snake_body,
   output logic [3:0] snake_length,
   output logic       collision
);

   typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DEAD} state_t;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   state_t     state;
   logic [6:0] seg_x [MAX_LEN];
   logic [6:0] seg_y [MAX_LEN];
   logic [3:0] length;
   logic [3:0] scan_idx;
   logic [1:0] cur_dir;
   logic       grow_pend;
   logic       tick_pend;

   logic [1:0] next_dir;
   logic [6:0] next_x;
   logic [6:0] next_y;
   logic       growing;
   logic       hit;
   logic [3:0] next_scan_idx;

   function automatic logic [6:0] init_x(input int i);
      return (i < INIT_LEN) ? 7'(START_X - i) : 7'd0;
   endfunction

   function automatic logic [6:0] init_y(input int i);
      return (i < INIT_LEN) ? 7'(START_Y) : 7'd0;
   endfunction

   assign snake_head_x = seg_x[0];
   assign snake_head_y = seg_y[0];
   assign snake_length = length;

   // Candidate move: the tail only counts as an obstacle when it will not vacate this move.
   always_comb begin
      next_dir = (direction == {cur_dir[1], ~cur_dir[0]}) ? cur_dir : direction;
      next_x   = seg_x[0];
      next_y   = seg_y[0];
      case (next_dir)
         DIR_UP:    next_y = (seg_y[0] == 7'd0) ? 7'(GRID_H - 1) : seg_y[0] - 7'd1;
         DIR_DOWN:  next_y = (seg_y[0] == 7'(GRID_H - 1)) ? 7'd0 : seg_y[0] + 7'd1;
         DIR_LEFT:  next_x = (seg_x[0] == 7'd0) ? 7'(GRID_W - 1) : seg_x[0] - 7'd1;
         default:   next_x = (seg_x[0] == 7'(GRID_W - 1)) ? 7'd0 : seg_x[0] + 7'd1;
      endcase
      growing = grow_pend && (length < 4'(MAX_LEN));
      hit     = 1'b0;
      for (int i = 1; i < MAX_LEN; i++) begin
         if ((i + 1 < int'(length)) || (growing && (i + 1 == int'(length)))) begin
            if ((seg_x[i] == next_x) && (seg_y[i] == next_y))
               hit = 1'b1;
         end
      end
      next_scan_idx = (scan_idx >= length - 4'd1) ? 4'd1 : scan_idx + 4'd1;
   end

   always_ff @(posedge clock_25 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= init_y(i);
         end
         length        <= 4'(INIT_LEN);
         cur_dir       <= DIR_RIGHT;
         scan_idx      <= 4'd1;
         snake_body_x  <= 7'd0;
         snake_body_y  <= 7'd0;
         en_snake_body <= 1'b0;
         collision     <= 1'b0;
         grow_pend     <= 1'b0;
         tick_pend     <= 1'b0;
         state         <= IDLE;
      end else if (!game_enable || (state == IDLE)) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= init_y(i);
         end
         length        <= 4'(INIT_LEN);
         cur_dir       <= DIR_RIGHT;
         scan_idx      <= 4'd1;
         snake_body_x  <= 7'd0;
         snake_body_y  <= 7'd0;
         en_snake_body <= 1'b0;
         collision     <= 1'b0;
         grow_pend     <= 1'b0;
         tick_pend     <= 1'b0;
         state         <= game_enable ? SCAN : IDLE;
      end else begin
         case (state)
            SCAN, DEAD: begin
               snake_body_x  <= seg_x[scan_idx];
               snake_body_y  <= seg_y[scan_idx];
               en_snake_body <= (length > 4'd1);
               scan_idx      <= next_scan_idx;
               if (grow)
                  grow_pend <= 1'b1;
               if ((state == SCAN) && (move_tick || tick_pend)) begin
                  tick_pend <= 1'b0;
                  state     <= UPDATE;
               end
            end
            UPDATE: begin
               en_snake_body <= 1'b0;
               scan_idx      <= 4'd1;
               grow_pend     <= grow;
               cur_dir       <= next_dir;
               if (move_tick)
                  tick_pend <= 1'b1;
               if (hit) begin
                  collision <= 1'b1;
                  state     <= DEAD;
               end else begin
                  for (int i = 1; i < MAX_LEN; i++) begin
                     seg_x[i] <= seg_x[i-1];
                     seg_y[i] <= seg_y[i-1];
                  end
                  seg_x[0] <= next_x;
                  seg_y[0] <= next_y;
                  if (growing)
                     length <= length + 4'd1;
                  state <= SCAN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_state_engine.sv
// Randomised bench for snake_state_engine: a queue-based snake model predicts head,
// length and collision, and a scoreboard checks the streamed body segments.
module tb_snake_state_engine;

   localparam int GRID_W   = 80;
   localparam int GRID_H   = 60;
   localparam int START_X  = 40;
   localparam int START_Y  = 30;
   localparam int INIT_LEN = 3;
   localparam int MAX_LEN  = 15;

   logic       clock_25;
   logic       reset;
   logic       game_enable;
   logic       move_tick;
   logic [1:0] direction;
   logic       grow;
   logic [6:0] snake_head_x;
   logic [6:0] snake_head_y;
   logic [6:0] snake_body_x;
   logic [6:0] snake_body_y;
   logic       en_snake_body;
   logic [3:0] snake_length;
   logic       collision;

   typedef struct {
      int x;
      int y;
   } pt_t;

   pt_t exp_q[$];
   int  mx[$];
   int  my[$];
   int  mdir;
   bit  mdead;
   int  errors;
   int  checks;

   snake_state_engine #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .START_X(START_X), .START_Y(START_Y),
      .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN)
   ) dut (
      .clock_25(clock_25),
      .reset(reset),
      .game_enable(game_enable),
      .move_tick(move_tick),
      .direction(direction),
      .grow(grow),
      .snake_head_x(snake_head_x),
      .snake_head_y(snake_head_y),
      .snake_body_x(snake_body_x),
      .snake_body_y(snake_body_y),
      .en_snake_body(en_snake_body),
      .snake_length(snake_length),
      .collision(collision)
   );

   initial clock_25 = 1'b0;
   always #5 clock_25 = ~clock_25;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic void model_reset();
      mx.delete();
      my.delete();
      for (int i = 0; i < INIT_LEN; i++) begin
         mx.push_back(START_X - i);
         my.push_back(START_Y);
      end
      mdir  = 3;
      mdead = 1'b0;
   endfunction

   // Snake as a list of cells, head first; a move prepends the new head and drops the tail.
   function automatic void model_move(input int dir, input bit g);
      int hx, hy, nd, lim;
      bit rev, growing, hit;
      if (mdead)
         return;
      rev = (dir == 0 && mdir == 1) || (dir == 1 && mdir == 0) ||
            (dir == 2 && mdir == 3) || (dir == 3 && mdir == 2);
      nd = rev ? mdir : dir;
      hx = mx[0];
      hy = my[0];
      case (nd)
         0:       hy = (hy + GRID_H - 1) % GRID_H;
         1:       hy = (hy + 1) % GRID_H;
         2:       hx = (hx + GRID_W - 1) % GRID_W;
         default: hx = (hx + 1) % GRID_W;
      endcase
      growing = g && (mx.size() < MAX_LEN);
      lim     = growing ? mx.size() - 1 : mx.size() - 2;
      hit     = 1'b0;
      for (int i = 1; i <= lim; i++)
         if (mx[i] == hx && my[i] == hy)
            hit = 1'b1;
      mdir = nd;
      if (hit) begin
         mdead = 1'b1;
         return;
      end
      mx.push_front(hx);
      my.push_front(hy);
      if (!growing) begin
         void'(mx.pop_back());
         void'(my.pop_back());
      end
   endfunction

   task automatic check_state(input string tag);
      check_output({tag, " head_x"}, int'(snake_head_x), mx[0]);
      check_output({tag, " head_y"}, int'(snake_head_y), my[0]);
      check_output({tag, " length"}, int'(snake_length), mx.size());
      check_output({tag, " collision"}, int'(collision), int'(mdead));
   endtask

   task automatic push_stream(input int reps);
      pt_t p;
      for (int r = 0; r < reps; r++) begin
         for (int i = 1; i < mx.size(); i++) begin
            p.x = mx[i];
            p.y = my[i];
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 64 && exp_q.size() != 0; c++)
         @(negedge clock_25);
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL stream_timeout: %0d segments never streamed, expected 0 left", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic apply_stimulus(input int dir, input bit g);
      bit was_dead;
      was_dead = mdead;
      @(negedge clock_25);
      direction = 2'(dir);
      grow      = g;
      move_tick = 1'b1;
      @(negedge clock_25);
      move_tick = 1'b0;
      grow      = 1'b0;
      @(negedge clock_25);
      model_move(dir, g);
      check_state("move");
      if (!was_dead) begin
         check_output("en_update_gap", int'(en_snake_body), 0);
         push_stream(1);
      end
      drain();
   endtask

   task automatic enable_game();
      @(negedge clock_25);
      game_enable = 1'b1;
      push_stream(1);
      drain();
   endtask

   task automatic disable_game();
      @(negedge clock_25);
      game_enable = 1'b0;
      @(negedge clock_25);
      model_reset();
      check_state("reinit");
      check_output("reinit en", int'(en_snake_body), 0);
   endtask

   // Scoreboard monitor: every qualified body sample is matched against the next expected cell.
   initial begin
      pt_t e;
      forever begin
         @(negedge clock_25);
         if (en_snake_body && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(snake_body_x) != e.x || int'(snake_body_y) != e.y) begin
               errors++;
               $display("[TB] FAIL body_stream: got (%0d,%0d), expected (%0d,%0d)",
                        snake_body_x, snake_body_y, e.x, e.y);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      errors      = 0;
      checks      = 0;
      reset       = 1'b1;
      game_enable = 1'b0;
      move_tick   = 1'b0;
      grow        = 1'b0;
      direction   = 2'b11;
      model_reset();
      #1 reset = 1'b0;
      #2;
      check_state("async_reset");
      check_output("reset en", int'(en_snake_body), 0);
      check_output("reset body_x", int'(snake_body_x), 0);
      check_output("reset body_y", int'(snake_body_y), 0);
      @(negedge clock_25);
      reset = 1'b1;
      @(negedge clock_25);
      check_state("idle");
      check_output("idle en", int'(en_snake_body), 0);

      // Free-running stream right after enabling, with en low only in the first cycle.
      @(negedge clock_25);
      game_enable = 1'b1;
      push_stream(2);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock_25);
         check_output("stream_en", int'(en_snake_body), (i > 0) ? 1 : 0);
      end
      drain();

      apply_stimulus(3, 1'b0);
      check_output("first_move head_x", int'(snake_head_x), 41);
      apply_stimulus(2, 1'b1);
      check_output("reverse_grow head_x", int'(snake_head_x), 42);
      check_output("reverse_grow length", int'(snake_length), 4);

      // A second tick during UPDATE is remembered and serviced right after.
      @(negedge clock_25);
      direction = 2'b11;
      move_tick = 1'b1;
      @(negedge clock_25);
      @(negedge clock_25);
      move_tick = 1'b0;
      model_move(3, 1'b0);
      check_state("tick_pend first");
      @(negedge clock_25);
      @(negedge clock_25);
      model_move(3, 1'b0);
      check_state("tick_pend second");
      check_output("tick_pend en", int'(en_snake_body), 0);
      push_stream(1);
      drain();

      while (mx[0] != GRID_W - 1 && !mdead)
         apply_stimulus(3, 1'b0);
      apply_stimulus(3, 1'b0);
      check_output("wrap_right head_x", int'(snake_head_x), 0);
      while (my[0] != 0 && !mdead)
         apply_stimulus(0, 1'b0);
      apply_stimulus(0, 1'b0);
      check_output("wrap_up head_y", int'(snake_head_y), GRID_H - 1);
      apply_stimulus(2, 1'b0);
      check_output("wrap_left head_x", int'(snake_head_x), GRID_W - 1);
      apply_stimulus(1, 1'b0);
      check_output("wrap_down head_y", int'(snake_head_y), 0);

      for (int n = 0; n < 40; n++)
         apply_stimulus(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));

      // Fold a length-5 snake back onto itself.
      disable_game();
      enable_game();
      apply_stimulus(3, 1'b1);
      apply_stimulus(3, 1'b1);
      apply_stimulus(0, 1'b0);
      apply_stimulus(2, 1'b0);
      apply_stimulus(1, 1'b0);
      check_output("self_collision", int'(collision), 1);
      apply_stimulus(3, 1'b0);
      check_output("dead_frozen head_x", int'(snake_head_x), 41);
      disable_game();
      check_output("collision_cleared", int'(collision), 0);

      // Dropping game_enable during UPDATE discards that move.
      enable_game();
      @(negedge clock_25);
      direction = 2'b11;
      move_tick = 1'b1;
      @(negedge clock_25);
      move_tick   = 1'b0;
      game_enable = 1'b0;
      @(negedge clock_25);
      model_reset();
      check_state("abort_update");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
